// File: rtl/dmem_bridge.sv
// dmem_bridge: single-outstanding bridge from the mem-stage request/response handshake to a Wishbone master port.
module dmem_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_d,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        err,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   state_t        state;
   logic [31:0]   a_q, d_q;
   logic [3:0]    be_q;
   logic          we_q;
   logic [CW-1:0] cnt;
   assign req_ready  = state == IDLE;
   assign wb_cyc_o   = state == BUS;
   assign wb_stb_o   = state == BUS;
   assign resp_valid = state == RESP;
   assign wb_adr_o   = a_q;
   assign wb_we_o    = we_q;
   assign wb_sel_o   = we_q ? be_q : 4'hF;
   assign wb_dat_o   = d_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_q       <= '0;
         d_q       <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         cnt       <= '0;
         resp_data <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               a_q       <= req_a;
               d_q       <= req_d;
               be_q      <= req_be;
               we_q      <= req_we;
               cnt       <= '0;
               resp_data <= '0;
               err       <= 1'b0;
               state     <= (req_we && req_be == 4'h0) ? RESP : BUS;
            end
            BUS: begin
               // bus error wins over a simultaneous ack; the counter expiring ends the access as an error
               if (wb_err_i || (!wb_ack_i && cnt == LAST)) begin
                  resp_data <= '0;
                  err       <= 1'b1;
                  state     <= RESP;
               end else if (wb_ack_i) begin
                  resp_data <= we_q ? 32'h0 : wb_dat_i;
                  err       <= 1'b0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: if (resp_ready) begin
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and randomized accesses against an outcome-level model of the bridge.
module tb_dmem_bridge;
   localparam int TO = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_a = '0, req_d = '0, wb_dat_i = '0;
   logic [3:0]  req_be = '0;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
   logic        req_ready, resp_valid, err, wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] resp_data, wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   int          checks = 0, errors = 0;

   dmem_bridge #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_we(req_we),
      .req_be(req_be), .req_d(req_d),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .err(err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i)
   );

   always #5 clk = ~clk;

   // mode: 0 ack, 1 err, 2 err+ack together, 3 never terminate; wt = wait cycles before termination
   task automatic access(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] d, input logic [31:0] rd, input int wt,
                         input int mode, input int hold, input string tag);
      int          exp_cyc, n, cyc;
      logic [31:0] exp_data;
      logic        exp_err;
      logic [72:0] exp_bus;
      if (we && be == 4'h0) begin
         exp_cyc = 0; exp_data = 0; exp_err = 0;
      end else if (mode == 3 || wt >= TO) begin
         exp_cyc = TO; exp_data = 0; exp_err = 1;
      end else begin
         exp_cyc = wt + 1; exp_err = (mode != 0); exp_data = (we || exp_err) ? 32'h0 : rd;
      end
      exp_bus = {1'b1, we, a, we ? be : 4'hF, d};
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b want 1", tag, req_ready); end
      req_valid = 1; req_a = a; req_we = we; req_be = be; req_d = d;
      @(negedge clk);
      req_valid = 0; req_a = $urandom; req_d = $urandom; req_be = 4'($urandom);
      n = 0; cyc = 0;
      while (!resp_valid && n < 40) begin
         n++;
         if (wb_cyc_o) begin
            cyc++;
            checks++;
            if ({wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== exp_bus) begin
               errors++;
               $display("FAIL %s bus_cycle%0d: got %h want %h", tag, cyc,
                        {wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, exp_bus);
            end
            if (mode != 3 && cyc == wt + 1) begin
               wb_ack_i = (mode != 1); wb_err_i = (mode != 0); wb_dat_i = rd;
            end
         end
         @(negedge clk);
         wb_ack_i = 0; wb_err_i = 0; wb_dat_i = $urandom;
      end
      checks++;
      if (n !== exp_cyc || cyc !== exp_cyc) begin
         errors++; $display("FAIL %s latency: got wait=%0d cyc=%0d want %0d", tag, n, cyc, exp_cyc);
      end
      checks++;
      if ({resp_valid, wb_cyc_o, resp_data, err} !== {2'b10, exp_data, exp_err}) begin
         errors++;
         $display("FAIL %s resp: got v=%b cyc=%b data=%h err=%b want v=1 cyc=0 data=%h err=%b",
                  tag, resp_valid, wb_cyc_o, resp_data, err, exp_data, exp_err);
      end
      for (int i = 0; i < hold; i++) begin
         wb_ack_i = 1; wb_err_i = 1'($urandom); wb_dat_i = $urandom;
         @(negedge clk);
         checks++;
         if ({resp_valid, req_ready, wb_cyc_o, resp_data, err} !== {3'b100, exp_data, exp_err}) begin
            errors++;
            $display("FAIL %s hold%0d: got v=%b rdy=%b cyc=%b data=%h err=%b want data=%h err=%b",
                     tag, i, resp_valid, req_ready, wb_cyc_o, resp_data, err, exp_data, exp_err);
         end
      end
      wb_ack_i = 0; wb_err_i = 0; resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      checks++;
      if ({req_ready, resp_valid, err} !== 3'b100) begin
         errors++; $display("FAIL %s release: got rdy=%b v=%b err=%b want 1 0 0", tag, req_ready, resp_valid, err);
      end
      wb_ack_i = 1; wb_err_i = 1;
      @(negedge clk);
      wb_ack_i = 0; wb_err_i = 0;
      checks++;
      if ({req_ready, resp_valid, wb_cyc_o} !== 3'b100) begin
         errors++; $display("FAIL %s idle_ack: got rdy=%b v=%b cyc=%b want 1 0 0", tag, req_ready, resp_valid, wb_cyc_o);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, resp_valid, err, wb_adr_o, wb_dat_o} !== '0) begin
         errors++; $display("FAIL reset_state: got cyc=%b stb=%b v=%b err=%b adr=%h dat=%h want all 0",
                            wb_cyc_o, wb_stb_o, resp_valid, err, wb_adr_o, wb_dat_o);
      end
      @(negedge clk);
      rst = 0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_read;
      access(32'h0000_1004, 0, 4'h3, 32'h0, 32'hA5B6_C7D8, 0, 0, 0, "read");
   endtask

   task automatic test_write;
      access(32'h0000_2000, 1, 4'b1100, 32'hBEEF_0000, 32'h1111_2222, 3, 0, 0, "write");
   endtask

   task automatic test_timeout;
      access(32'h0000_3008, 0, 4'hF, 32'h0, 32'h5555_AAAA, 0, 3, 2, "timeout");
   endtask

   task automatic test_err_ack;
      access(32'h0000_400C, 0, 4'hF, 32'h0, 32'h1234_5678, 1, 2, 0, "err_ack");
   endtask

   task automatic test_zero_be;
      access(32'h0000_5000, 1, 4'h0, 32'hDEAD_BEEF, 32'h7777_7777, 0, 0, 3, "zero_be");
   endtask

   task automatic test_reset_mid_bus;
      @(negedge clk);
      req_valid = 1; req_a = 32'h6000; req_we = 0; req_be = 4'hF;
      @(negedge clk);
      req_valid = 0;
      checks++;
      if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_bus_enter: got cyc=%b want 1", wb_cyc_o); end
      #2 rst = 1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, resp_valid} !== 3'b000) begin
         errors++; $display("FAIL rst_bus_drop: got cyc=%b stb=%b v=%b want 0 0 0", wb_cyc_o, wb_stb_o, resp_valid);
      end
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         wb_ack_i = (i == 0);
         @(negedge clk);
         wb_ack_i = 0;
         checks++;
         if ({resp_valid, wb_cyc_o, req_ready} !== 3'b001) begin
            errors++; $display("FAIL rst_bus_after%0d: got v=%b cyc=%b rdy=%b want 0 0 1", i, resp_valid, wb_cyc_o, req_ready);
         end
      end
      access(32'h0000_7004, 0, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 0, 1, "after_rst");
   endtask

   task automatic test_random;
      logic [31:0] a;
      for (int k = 0; k < 40; k++) begin
         a = $urandom & 32'hFFFF_FFFC;
         access(a, 1'($urandom), 4'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "random");
      end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write;
      test_timeout;
      test_err_ack;
      test_zero_be;
      test_reset_mid_bus;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, max bus wait cycles per access before forced abort (1..65535).
REQ-002 clk  input  1  clock, all state rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  decoupled.in  {a[31:0], we, be[3:0], d[31:0]}  memory request from the mem stage; a word-aligned, d pre-shifted.
REQ-005 resp  decoupled.out  32  response word, raw unshifted read data; 0 for writes.
REQ-006 wb_cyc_o  output  1  bus cycle active.
REQ-007 wb_stb_o  output  1  bus strobe.
REQ-008 wb_we_o  output  1  bus write enable.
REQ-009 wb_adr_o  output  32  bus address.
REQ-010 wb_sel_o  output  4  bus byte selects.
REQ-011 wb_dat_o  output  32  bus write data.
REQ-012 wb_dat_i  input  32  bus read data, valid with wb_ack_i.
REQ-013 wb_ack_i  input  1  bus access complete.
REQ-014 wb_err_i  input  1  bus access failed.
REQ-015 err  output  1  high exactly while resp.valid for an aborted access (bus error or timeout).

Function
REQ-016 FSM states IDLE, BUS, RESP; single outstanding access.
REQ-017 req.ready SHALL be 1 only in IDLE; req.valid&&req.ready latches a, we, be, d into holding registers.
REQ-018 IDLE, accept, be!=0 or we=0 -> BUS next cycle.
REQ-019 IDLE, accept, we=1 and be=0 -> RESP next cycle, no bus cycle, resp.data 0, err 0.
REQ-020 In BUS, wb_cyc_o=wb_stb_o=1, wb_adr_o/wb_we_o/wb_sel_o/wb_dat_o SHALL drive the holding registers, stable until termination.
REQ-021 Reads drive wb_sel_o=4'b1111 regardless of req.be.
REQ-022 BUS, wb_ack_i=1 -> RESP next cycle; read: resp.data=wb_dat_i sampled that edge; write: resp.data=0; err 0.
REQ-023 BUS, wb_err_i=1 -> RESP with resp.data 0, err 1; wb_err_i takes priority over simultaneous wb_ack_i.
REQ-024 Wait counter cleared on BUS entry, +1 per BUS cycle without ack/err; if counter reaches TIMEOUT without termination -> RESP, resp.data 0, err 1, cyc/stb deasserted next cycle.
REQ-025 Minimum latency: accept edge N, stb high cycle N+1, ack in N+1 -> resp.valid cycle N+2.
REQ-026 RESP: resp.valid=1, resp.data/err held stable until resp.valid&&resp.ready, then IDLE next cycle.
REQ-027 wb_ack_i/wb_err_i outside BUS SHALL be ignored, no state change.
REQ-028 Outputs wb_cyc_o, wb_stb_o, resp.valid, err registered or decoded from registered state only, with no combinational path from req or wb inputs.
REQ-029 Counter width SHALL be $clog2(TIMEOUT+1); no wrap before TIMEOUT.

Reset
REQ-030 rst asserted: state IDLE, wb_cyc_o=0, wb_stb_o=0, resp.valid=0, err=0, counter 0, holding registers 0, all immediately (asynchronous).
REQ-031 rst mid-BUS SHALL drop cyc/stb without waiting for ack; the aborted access produces no response after reset release.
REQ-032 First cycle after rst deassert: req.ready=1.

Verification
REQ-033 Read a=0x0000_1004, ack on 1st BUS cycle, wb_dat_i=0xA5B6C7D8 -> wb_sel_o=4'hF, wb_we_o=0, resp.valid at N+2, resp.data=0xA5B6C7D8, err 0.
REQ-034 Write a=0x2000, be=4'b1100, d=0xBEEF0000, ack after 3 wait cycles -> adr/sel/dat stable all 4 BUS cycles, resp.data=0, err 0, then req.ready=1.
REQ-035 TIMEOUT=4, read, no ack -> cyc/stb high exactly 4 cycles, then resp.valid with data 0, err 1; later ack ignored.
REQ-036 wb_err_i and wb_ack_i together on a read with wb_dat_i=0x12345678 -> resp.data=0, err 1.
REQ-037 Write be=0 -> wb_cyc_o never asserted, resp.valid next cycle; resp.ready held 0 for 3 cycles -> resp.valid and data stable, req.ready=0 throughout.
REQ-038 rst pulsed while in BUS -> wb_cyc_o=0 same cycle, no resp.valid afterwards, next request completes normally.
